// File: rtl/link_tx_pkg.sv
// ============================================================================
// Module      : link_tx_pkg
// Description : Shared types and link constants for the inter-board serial link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package link_tx_pkg;

    // Local player frame; the receive side unpacks the same layout.
    typedef struct packed {
        logic [10:0] pos_x;
        logic [9:0]  pos_y;
        logic [6:0]  anim;
        logic [3:0]  flags;
    } data_t;

    localparam int LINK_CLK_DIV    = 4;
    localparam int LINK_GAP_CYCLES = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOW   = 3'd1,
        S_HIGH  = 3'd2,
        S_TRAIL = 3'd3,
        S_GAP   = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/link_tx_if.sv
// ============================================================================
// Module      : link_tx_if
// Description : Word-in handshake plus three-wire serial link of link_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface link_tx_if
    import link_tx_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(data_t)
) ();

    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid_in;
    logic                  ready_out;
    logic                  data_out;
    logic                  data_clk_out;
    logic                  sel_out;
    logic                  done_out;
    logic                  overwrite_out;

    // Upstream producer of words; also observes the link.
    modport master (
        output data_in,
        output data_valid_in,
        input  ready_out,
        input  data_out,
        input  data_clk_out,
        input  sel_out,
        input  done_out,
        input  overwrite_out
    );

    // The serializer itself.
    modport slave (
        input  data_in,
        input  data_valid_in,
        output ready_out,
        output data_out,
        output data_clk_out,
        output sel_out,
        output done_out,
        output overwrite_out
    );

endinterface

`default_nettype wire

// File: rtl/link_tx.sv
// ============================================================================
// Module      : link_tx
// Description : Serializes the freshest local frame MSB-first onto the link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_tx
    import link_tx_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(data_t),
    parameter int CLK_DIV    = LINK_CLK_DIV,
    parameter int GAP_CYCLES = LINK_GAP_CYCLES
) (
    input  wire logic clk_pixel_in,
    input  wire logic rst_in,
    link_tx_if.slave  link
);

    localparam int c_hw = $clog2(CLK_DIV);
    localparam int c_bw = $clog2(DATA_WIDTH);
    localparam int c_gw = $clog2(GAP_CYCLES + 1);

    localparam logic [c_hw-1:0] c_half_last = c_hw'(CLK_DIV - 1);
    localparam logic [c_bw-1:0] c_bit_last  = c_bw'(DATA_WIDTH - 1);
    localparam logic [c_gw-1:0] c_gap_last  = c_gw'(GAP_CYCLES - 1);

    tx_state_t             r_state,      w_state_nxt;
    logic [c_hw-1:0]       r_half_cnt,   w_half_nxt;
    logic [c_bw-1:0]       r_bit_cnt,    w_bit_nxt;
    logic [c_gw-1:0]       r_gap_cnt,    w_gap_nxt;
    logic [DATA_WIDTH-1:0] r_shift,      w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_pend_data,  w_pend_data_nxt;
    logic                  r_pend_valid, w_pend_valid_nxt;
    logic                  r_sel,        w_sel_nxt;
    logic                  r_dclk,       w_dclk_nxt;
    logic                  r_ready,      w_ready_nxt;
    logic                  r_done,       w_done_nxt;
    logic                  r_ovw,        w_ovw_nxt;

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_half_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '0;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
            r_sel        <= 1'b1;
            r_dclk       <= 1'b0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_ovw        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_half_cnt   <= w_half_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_shift      <= w_shift_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_sel        <= w_sel_nxt;
            r_dclk       <= w_dclk_nxt;
            r_ready      <= w_ready_nxt;
            r_done       <= w_done_nxt;
            r_ovw        <= w_ovw_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_half_nxt       = r_half_cnt;
        w_bit_nxt        = r_bit_cnt;
        w_gap_nxt        = r_gap_cnt;
        w_shift_nxt      = r_shift;
        w_pend_data_nxt  = r_pend_data;
        w_pend_valid_nxt = r_pend_valid;
        w_sel_nxt        = r_sel;
        w_dclk_nxt       = r_dclk;
        w_done_nxt       = 1'b0;
        w_ovw_nxt        = 1'b0;

        // Any strobe while busy lands in the pending slot; the shift register is untouched.
        if (r_state != S_IDLE && link.data_valid_in) begin
            w_pend_data_nxt  = link.data_in;
            w_pend_valid_nxt = 1'b1;
            w_ovw_nxt        = r_pend_valid;
        end

        case (r_state)
            S_IDLE: begin
                if (link.data_valid_in) begin
                    w_state_nxt = S_LOW;
                    w_shift_nxt = link.data_in;
                    w_half_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_sel_nxt   = 1'b0;
                    w_dclk_nxt  = 1'b0;
                end
            end
            S_LOW: begin
                if (r_half_cnt == c_half_last) begin
                    w_state_nxt = S_HIGH;
                    w_half_nxt  = '0;
                    w_dclk_nxt  = 1'b1;
                end else begin
                    w_half_nxt = r_half_cnt + c_hw'(1);
                end
            end
            S_HIGH: begin
                if (r_half_cnt == c_half_last) begin
                    w_half_nxt = '0;
                    w_dclk_nxt = 1'b0;
                    if (r_bit_cnt == c_bit_last) begin
                        w_state_nxt = S_TRAIL;
                        w_bit_nxt   = '0;
                    end else begin
                        // Shift on the falling edge so data settles during the low phase.
                        w_state_nxt = S_LOW;
                        w_bit_nxt   = r_bit_cnt + c_bw'(1);
                        w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    w_half_nxt = r_half_cnt + c_hw'(1);
                end
            end
            S_TRAIL: begin
                if (r_half_cnt == c_half_last) begin
                    w_state_nxt = S_GAP;
                    w_half_nxt  = '0;
                    w_gap_nxt   = '0;
                    w_sel_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_half_nxt = r_half_cnt + c_hw'(1);
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_gap_nxt = '0;
                    if (link.data_valid_in || r_pend_valid) begin
                        // A strobe on the exit cycle is fresher than the pending word.
                        w_state_nxt      = S_LOW;
                        w_shift_nxt      = link.data_valid_in ? link.data_in : r_pend_data;
                        w_pend_valid_nxt = 1'b0;
                        w_half_nxt       = '0;
                        w_bit_nxt        = '0;
                        w_sel_nxt        = 1'b0;
                        w_dclk_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + c_gw'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = 1'b1;
                w_dclk_nxt  = 1'b0;
            end
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    assign link.ready_out     = r_ready;
    assign link.data_out      = r_shift[DATA_WIDTH-1];
    assign link.data_clk_out  = r_dclk;
    assign link.sel_out       = r_sel;
    assign link.done_out      = r_done;
    assign link.overwrite_out = r_ovw;

endmodule

`default_nettype wire

// File: tb/tb_link_tx.sv
// ============================================================================
// Module      : tb_link_tx
// Description : Scoreboard bench for link_tx at default link parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_link_tx;
    import link_tx_pkg::*;

    localparam int c_w = 32;

    logic clk_pixel_in = 1'b0;
    logic rst_in       = 1'b1;

    link_tx_if #(.DATA_WIDTH(c_w)) lnk ();

    link_tx #(
        .DATA_WIDTH (c_w),
        .CLK_DIV    (4),
        .GAP_CYCLES (8)
    ) u_dut (
        .clk_pixel_in (clk_pixel_in),
        .rst_in       (rst_in),
        .link         (lnk)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int t0       = 0;

    logic [c_w-1:0] sb_q[$];

    int        frames_done = 0;
    int        done_cnt = 0, ovw_cnt = 0, stab_err = 0;
    int        nbits = 0, fall_cyc = -1, rise_cyc = -1, done_cyc = -1;
    int        ovw_cyc = -1, ready_cyc = -1, first_rise_cyc = -1, last_fall_cyc = -1;
    logic      in_frame = 1'b0;
    logic [c_w-1:0] rx_word = '0;
    logic      prev_sel = 1'b1, prev_dclk = 1'b0, prev_dout = 1'b0, prev_ready = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_pixel_in) edge_n <= edge_n + 1;

    // Link monitor: values seen here belong to cycle (edge_n - t0).
    always @(posedge clk_pixel_in) begin
        #1;
        if (rst_in) begin
            in_frame = 1'b0;
        end else begin
            if (prev_sel && !lnk.sel_out) begin
                fall_cyc = edge_n - t0;
                nbits    = 0;
                rx_word  = '0;
                in_frame = 1'b1;
            end
            if (!prev_dclk && lnk.data_clk_out) begin
                rx_word = {rx_word[c_w-2:0], lnk.data_out};
                nbits++;
                if (nbits == 1) first_rise_cyc = edge_n - t0;
                if (lnk.data_out != prev_dout) stab_err++;
            end
            if (prev_dclk && lnk.data_clk_out && lnk.data_out != prev_dout) stab_err++;
            if (prev_dclk && !lnk.data_clk_out) last_fall_cyc = edge_n - t0;
            if (!prev_sel && lnk.sel_out && in_frame) begin
                rise_cyc = edge_n - t0;
                in_frame = 1'b0;
                frames_done++;
                chk("bit count", nbits, c_w);
                chk("done with sel rise", {31'd0, lnk.done_out}, 32'd1);
                if (sb_q.size() == 0) chk("unexpected frame", rx_word, 32'hDEAD_BEEF);
                else                  chk("frame data", rx_word, sb_q.pop_front());
            end
            if (lnk.done_out) begin done_cnt++; done_cyc = edge_n - t0; end
            if (lnk.overwrite_out) begin ovw_cnt++; ovw_cyc = edge_n - t0; end
            if (lnk.ready_out && !prev_ready) ready_cyc = edge_n - t0;
        end
        prev_sel   = lnk.sel_out;
        prev_dclk  = lnk.data_clk_out;
        prev_dout  = lnk.data_out;
        prev_ready = lnk.ready_out;
    end

    // Caller is positioned at a negedge; the next posedge captures the word.
    task automatic send(input logic [c_w-1:0] d, input bit mark, input bit replace);
        lnk.data_in       = d;
        lnk.data_valid_in = 1'b1;
        if (mark) t0 = edge_n;
        if (replace && sb_q.size() > 0) void'(sb_q.pop_back());
        sb_q.push_back(d);
        @(negedge clk_pixel_in);
        lnk.data_valid_in = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (edge_n < t0 + n) @(negedge clk_pixel_in);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!lnk.ready_out && n < budget) begin
            @(negedge clk_pixel_in);
            n++;
        end
        chk("idle within budget", {31'd0, lnk.ready_out}, 32'd1);
        @(negedge clk_pixel_in);
    endtask

    int ovw0, done0, frames0;

    initial begin
        lnk.data_in       = '0;
        lnk.data_valid_in = 1'b0;
        repeat (3) @(negedge clk_pixel_in);
        chk("reset sel", {31'd0, lnk.sel_out}, 32'd1);
        chk("reset dclk", {31'd0, lnk.data_clk_out}, 32'd0);
        chk("reset dout", {31'd0, lnk.data_out}, 32'd0);
        chk("reset ready", {31'd0, lnk.ready_out}, 32'd1);
        chk("reset done", {31'd0, lnk.done_out}, 32'd0);
        chk("reset ovw", {31'd0, lnk.overwrite_out}, 32'd0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_pixel_in);

        // Single frame with full timing
        send(32'hA5C3_0F01, 1'b1, 1'b0);
        wait_idle(400);
        chk("s1 sel fall cycle", fall_cyc, 1);
        chk("s1 first rise cycle", first_rise_cyc, 5);
        chk("s1 last fall cycle", last_fall_cyc, 257);
        chk("s1 sel rise cycle", rise_cyc, 261);
        chk("s1 done cycle", done_cyc, 261);
        chk("s1 ready cycle", ready_cyc, 269);
        chk("s1 done count", done_cnt, 1);
        chk("s1 data stability", stab_err, 0);

        // Back-to-back, no overwrite
        ovw0 = ovw_cnt;
        send(32'h1111_1111, 1'b1, 1'b0);
        wait_cyc(50);
        send(32'h2222_2222, 1'b0, 1'b0);
        wait_cyc(270);
        chk("b2b second sel fall", fall_cyc, 269);
        chk("b2b ready held low", {31'd0, lnk.ready_out}, 32'd0);
        wait_idle(400);
        chk("b2b no overwrite", ovw_cnt - ovw0, 0);

        // Overwrite of a pending word
        ovw0 = ovw_cnt;
        send(32'h0000_0001, 1'b1, 1'b0);
        wait_cyc(40);
        send(32'h0000_0002, 1'b0, 1'b0);
        wait_cyc(80);
        send(32'h0000_0003, 1'b0, 1'b1);
        wait_idle(700);
        chk("ovw pulse cycle", ovw_cyc, 81);
        chk("ovw pulse count", ovw_cnt - ovw0, 1);

        // Strobe on the GAP exit cycle with a word pending
        ovw0 = ovw_cnt;
        send(32'h0000_0001, 1'b1, 1'b0);
        wait_cyc(40);
        send(32'h0000_0002, 1'b0, 1'b0);
        wait_cyc(268);
        send(32'h0000_0004, 1'b0, 1'b1);
        wait_idle(400);
        chk("gap exit ovw cycle", ovw_cyc, 269);
        chk("gap exit ovw count", ovw_cnt - ovw0, 1);
        chk("gap exit sel fall", fall_cyc, 269);

        // Reset mid-frame
        frames0 = frames_done;
        send(32'h0F0F_0F0F, 1'b1, 1'b0);
        wait_cyc(100);
        rst_in = 1'b1;
        #1;
        chk("mid reset sel", {31'd0, lnk.sel_out}, 32'd1);
        chk("mid reset dclk", {31'd0, lnk.data_clk_out}, 32'd0);
        chk("mid reset ready", {31'd0, lnk.ready_out}, 32'd1);
        sb_q.delete();
        done0 = done_cnt;
        repeat (4) @(negedge clk_pixel_in);
        rst_in = 1'b0;
        repeat (200) @(negedge clk_pixel_in);
        chk("mid reset no done", done_cnt - done0, 0);
        chk("mid reset no frame", frames_done - frames0, 0);
        send(32'h5A5A_C3C3, 1'b1, 1'b0);
        wait_idle(400);
        chk("post reset frame", frames_done - frames0, 1);

        chk("scoreboard empty", sb_q.size(), 0);
        chk("total frames", frames_done, 8);
        chk("global stability", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
